// File: rtl/coef_loader.sv
// Coefficient frame loader: collects NTAP words into a shadow bank and swaps
// them into the active FIR coefficient bank on the next sample boundary.
module coef_loader #(
    parameter int unsigned        NTAP   = 16,
    parameter logic signed [15:0] RST_C0 = 16'sh7FFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      in_data,
    input  logic                    in_last,
    input  logic                    sample_tick,
    input  logic                    abort,
    output logic [NTAP-1:0][15:0]   coef,
    output logic                    coef_updated,
    output logic                    frame_err,
    output logic                    busy,
    output logic [7:0]              commit_cnt
);

    localparam int unsigned IDX_W = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAP - 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOAD      = 2'd1;
    localparam logic [1:0] WAIT_SWAP = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             err_nxt;
    logic             commit_nxt;
    logic             xfer;
    logic [15:0]      shadow [NTAP];

    // in_ready is a register, so the handshake never depends on inputs
    assign xfer = in_valid && in_ready;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            coef_updated <= 1'b0;
            commit_cnt   <= '0;
            coef         <= '0;
            coef[0]      <= RST_C0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            in_ready     <= (state_nxt != WAIT_SWAP);
            busy         <= (state_nxt != IDLE);
            frame_err    <= err_nxt;
            coef_updated <= commit_nxt;
            if (commit_nxt) begin
                commit_cnt <= commit_cnt + 8'd1;
                for (int i = 0; i < int'(NTAP); i++) begin
                    coef[i] <= shadow[i];
                end
            end
        end
    end

    // Shadow bank needs no reset: every committed frame rewrites all taps
    always_ff @(posedge clk) begin
        if (xfer) begin
            shadow[idx] <= in_data;
        end
    end

    // Next-state logic; IDLE always holds idx=0, so it shares LOAD's word rules
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        err_nxt    = 1'b0;
        commit_nxt = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (state == LOAD && abort) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (xfer) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (in_last) begin
                            state_nxt = WAIT_SWAP;
                        end else begin
                            state_nxt = IDLE;
                            err_nxt   = 1'b1;
                        end
                    end else if (in_last) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end
            end
            WAIT_SWAP: begin
                if (abort) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else if (sample_tick) begin
                    state_nxt  = IDLE;
                    idx_nxt    = '0;
                    commit_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_coef_loader.sv
// Directed bench for coef_loader: per-cycle vector table plus hand-written
// multi-cycle frame sequences against a bench-side expected coefficient bank.
module tb_coef_loader;

    localparam int NTAP = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [15:0]    in_data = '0;
    logic                  in_last = 1'b0;
    logic                  sample_tick = 1'b0;
    logic                  abort = 1'b0;
    logic [NTAP-1:0][15:0] coef;
    logic                  coef_updated;
    logic                  frame_err;
    logic                  busy;
    logic [7:0]            commit_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_coef [NTAP];
    logic [7:0]  exp_cnt;

    coef_loader #(.NTAP(NTAP), .RST_C0(16'sh7FFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .sample_tick  (sample_tick),
        .abort        (abort),
        .coef         (coef),
        .coef_updated (coef_updated),
        .frame_err    (frame_err),
        .busy         (busy),
        .commit_cnt   (commit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          r, v, l, t, a;
        logic [15:0] d;
        bit          e_ready, e_err, e_upd, e_busy;
        logic [7:0]  e_cnt;
        logic [15:0] e_c0;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; in_valid = 0; in_last = 0; sample_tick = 0; abort = 0; in_data = '0;
    endtask

    task automatic set_reset_model();
        for (int i = 0; i < NTAP; i++) exp_coef[i] = '0;
        exp_coef[0] = 16'h7FFF;
        exp_cnt = 8'd0;
    endtask

    task automatic check_bank(input string name);
        for (int i = 0; i < NTAP; i++) begin
            check($sformatf("%s_coef%0d", name, i), 32'(coef[i]), 32'(exp_coef[i]));
        end
    endtask

    task automatic check_flags(input string name, input bit rdy, input bit err,
                               input bit upd, input bit bsy);
        check({name, "_ready"}, 32'(in_ready), 32'(rdy));
        check({name, "_err"},   32'(frame_err), 32'(err));
        check({name, "_upd"},   32'(coef_updated), 32'(upd));
        check({name, "_busy"},  32'(busy), 32'(bsy));
        check({name, "_cnt"},   32'(commit_cnt), 32'(exp_cnt));
    endtask

    // Sends n words base+i; in_last on word last_at (-1 for none)
    task automatic send_frame(input logic [15:0] base, input int n, input int last_at,
                              input bit tick_on_last);
        for (int i = 0; i < n; i++) begin
            in_valid    = 1;
            in_data     = 16'(base + 16'(i));
            in_last     = (i == last_at);
            sample_tick = tick_on_last && (i == n - 1);
            cyc();
        end
        clear_inputs();
    endtask

    task automatic model_commit(input logic [15:0] base);
        for (int i = 0; i < NTAP; i++) exp_coef[i] = 16'(base + 16'(i));
        exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        //            r v l t a  d       rdy err upd bsy cnt  c0
        tbl[0]  = '{1,0,0,0,0, 16'h0,  1, 0, 0, 0, 8'd0, 16'h7FFF};
        tbl[1]  = '{0,1,1,0,0, 16'h5,  1, 1, 0, 0, 8'd0, 16'h7FFF};
        tbl[2]  = '{0,0,0,0,0, 16'h0,  1, 0, 0, 0, 8'd0, 16'h7FFF};
        tbl[3]  = '{0,1,0,0,1, 16'h9,  1, 0, 0, 1, 8'd0, 16'h7FFF};
        tbl[4]  = '{0,0,0,1,0, 16'h0,  1, 0, 0, 1, 8'd0, 16'h7FFF};
        tbl[5]  = '{0,0,0,0,1, 16'h0,  1, 0, 0, 0, 8'd0, 16'h7FFF};
        tbl[6]  = '{0,1,0,0,0, 16'h1,  1, 0, 0, 1, 8'd0, 16'h7FFF};
        tbl[7]  = '{0,1,0,0,0, 16'h2,  1, 0, 0, 1, 8'd0, 16'h7FFF};
        tbl[8]  = '{0,1,0,1,0, 16'h3,  1, 0, 0, 1, 8'd0, 16'h7FFF};
        tbl[9]  = '{0,1,0,0,0, 16'h4,  1, 0, 0, 1, 8'd0, 16'h7FFF};
        tbl[10] = '{0,1,1,0,0, 16'h5,  1, 1, 0, 0, 8'd0, 16'h7FFF};
        tbl[11] = '{0,0,0,0,0, 16'h0,  1, 0, 0, 0, 8'd0, 16'h7FFF};

        set_reset_model();
        #2;
        // Per-cycle vectors: reset, IDLE errors, abort in IDLE/LOAD, short frame
        for (int k = 0; k < 12; k++) begin
            rst = tbl[k].r; in_valid = tbl[k].v; in_last = tbl[k].l;
            sample_tick = tbl[k].t; abort = tbl[k].a; in_data = tbl[k].d;
            cyc();
            clear_inputs();
            check($sformatf("vec%0d_ready", k), 32'(in_ready), 32'(tbl[k].e_ready));
            check($sformatf("vec%0d_err", k),   32'(frame_err), 32'(tbl[k].e_err));
            check($sformatf("vec%0d_upd", k),   32'(coef_updated), 32'(tbl[k].e_upd));
            check($sformatf("vec%0d_busy", k),  32'(busy), 32'(tbl[k].e_busy));
            check($sformatf("vec%0d_cnt", k),   32'(commit_cnt), 32'(tbl[k].e_cnt));
            check($sformatf("vec%0d_c0", k),    32'(coef[0]), 32'(tbl[k].e_c0));
        end
        check_bank("after_vec");

        // Full frame 1..16; tick on the last-word edge must be ignored
        send_frame(16'd1, NTAP, NTAP - 1, 1'b1);
        check_flags("a_wait", 0, 0, 0, 1);
        check_bank("a_wait");
        cyc();
        cyc();
        check_flags("a_wait2", 0, 0, 0, 1);
        sample_tick = 1;
        cyc();
        clear_inputs();
        model_commit(16'd1);
        check_flags("a_commit", 1, 0, 1, 0);
        check_bank("a_commit");
        cyc();
        check_flags("a_after", 1, 0, 0, 0);

        // 16 words without in_last, then a good frame
        send_frame(16'd50, NTAP, -1, 1'b0);
        check_flags("b_err", 1, 1, 0, 0);
        check_bank("b_err");
        send_frame(16'd100, NTAP, NTAP - 1, 1'b0);
        sample_tick = 1;
        cyc();
        clear_inputs();
        model_commit(16'd100);
        check_flags("b_commit", 1, 0, 1, 0);
        check_bank("b_commit");

        // Abort together with sample_tick in WAIT_SWAP
        send_frame(16'd200, NTAP, NTAP - 1, 1'b0);
        abort = 1; sample_tick = 1;
        cyc();
        clear_inputs();
        check_flags("c_abort", 1, 0, 0, 0);
        check_bank("c_abort");
        sample_tick = 1;
        cyc();
        clear_inputs();
        check_flags("c_late_tick", 1, 0, 0, 0);
        check_bank("c_late_tick");

        // Reset after 8 words, then reset with tick while in WAIT_SWAP
        send_frame(16'd300, 8, -1, 1'b0);
        rst = 1;
        cyc();
        clear_inputs();
        set_reset_model();
        check_flags("d_rst", 1, 0, 0, 0);
        check_bank("d_rst");
        send_frame(16'd350, NTAP, NTAP - 1, 1'b0);
        rst = 1; sample_tick = 1;
        cyc();
        clear_inputs();
        check_flags("d_rst_wait", 1, 0, 0, 0);
        check_bank("d_rst_wait");
        send_frame(16'd400, NTAP, NTAP - 1, 1'b0);
        sample_tick = 1;
        cyc();
        clear_inputs();
        model_commit(16'd400);
        check_flags("d_commit", 1, 0, 1, 0);
        check_bank("d_commit");

        // 256 commits: counter wraps; in_ready low through every wait interval
        for (int f = 0; f < 256; f++) begin
            send_frame(16'(f * 16 + 7), NTAP, NTAP - 1, 1'b0);
            for (int w = 0; w < (f % 3); w++) begin
                check($sformatf("e%0d_wait_ready", f), 32'(in_ready), 32'd0);
                cyc();
            end
            check($sformatf("e%0d_tick_ready", f), 32'(in_ready), 32'd0);
            sample_tick = 1;
            cyc();
            clear_inputs();
            model_commit(16'(f * 16 + 7));
            check($sformatf("e%0d_cnt", f), 32'(commit_cnt), 32'(exp_cnt));
            check($sformatf("e%0d_upd", f), 32'(coef_updated), 32'd1);
            if (f == 254) check("e_wrap_zero", 32'(commit_cnt), 32'd0);
        end
        check_bank("e_final");
        check("e_final_cnt", 32'(commit_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
